// File: rtl/frame_swap_scheduler.sv
// Double-buffer sequencer: owns the front/back buffer select, drives the
// back-buffer clear, gates rasteriser writes and swaps only at vblank start.
module frame_swap_scheduler #(
  parameter int unsigned VSYNC_ACTIVE_LOW  = 1,
  parameter int unsigned CLEAR_ON_SWAP     = 1,
  parameter int unsigned FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         vsync,
  input  logic                         swap_req,
  input  logic                         clear_req,
  input  logic                         fill_done,
  input  logic                         writing_done,
  output logic                         front_buffer,
  output logic                         back_buffer,
  output logic                         fill_background,
  output logic                         draw_enable,
  output logic                         swap_pending,
  output logic                         req_dropped,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

  typedef enum logic [2:0] {
    CLEAR_START,
    CLEAR,
    DRAW,
    FLUSH,
    WAIT_VBLANK,
    SWAP
  } state_t;

  localparam logic                         VSYNC_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [FRAME_COUNT_WIDTH-1:0] COUNT_ONE  = {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  logic vsync_meta;
  logic vsync_sync;
  logic vblank_prev;
  logic vblank_level;
  logic vblank_start;

  logic fill_next;
  logic drop_next;
  logic swap_now;

  // vsync arrives from the pixel-clock domain; two flops plus an edge-history flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_meta  <= VSYNC_IDLE;
      vsync_sync  <= VSYNC_IDLE;
      vblank_prev <= 1'b0;
    end else begin
      vsync_meta  <= vsync;
      vsync_sync  <= vsync_meta;
      vblank_prev <= vblank_level;
    end
  end

  assign vblank_level = vsync_sync ^ VSYNC_IDLE;
  assign vblank_start = vblank_level & ~vblank_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR_START;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      CLEAR_START: state_next = CLEAR;
      CLEAR: begin
        if (fill_done) state_next = DRAW;
      end
      DRAW: begin
        if (swap_req)       state_next = FLUSH;
        else if (clear_req) state_next = CLEAR_START;
      end
      FLUSH: begin
        if (writing_done) state_next = WAIT_VBLANK;
      end
      WAIT_VBLANK: begin
        if (vblank_start) state_next = SWAP;
      end
      SWAP: state_next = (CLEAR_ON_SWAP != 0) ? CLEAR_START : DRAW;
      default: state_next = CLEAR_START;
    endcase
  end

  always_comb begin
    draw_enable  = 1'b0;
    swap_pending = 1'b0;
    fill_next    = 1'b0;
    swap_now     = 1'b0;
    drop_next    = 1'b0;
    unique case (state)
      CLEAR_START: fill_next = 1'b1;
      DRAW: begin
        draw_enable = 1'b1;
        drop_next   = swap_req & clear_req;
      end
      FLUSH, WAIT_VBLANK: swap_pending = 1'b1;
      SWAP: swap_now = 1'b1;
      default: ;
    endcase
    if (state != DRAW) drop_next = swap_req | clear_req;
  end

  // Fill command and drop flag are registered so both read 0 throughout reset;
  // the fill pulse therefore lands in the cycle after CLEAR_START.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front_buffer    <= 1'b0;
      frame_count     <= '0;
      fill_background <= 1'b0;
      req_dropped     <= 1'b0;
    end else begin
      fill_background <= fill_next;
      req_dropped     <= drop_next;
      if (swap_now) begin
        front_buffer <= ~front_buffer;
        frame_count  <= frame_count + COUNT_ONE;
      end
    end
  end

  assign back_buffer = ~front_buffer;

endmodule
